// File: rtl/sensor_pkg.sv
// Shared definitions for the timeout-converter arbiter: FSM encoding,
// default sizing and operand widths.
package sensor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } arb_state_e;

    localparam int DEF_NUM_REQ     = 4;
    localparam int DEF_WDOG_CYCLES = 15;
    localparam int MCLKS_W         = 16;
    localparam int PCLKS_W         = 8;
    localparam int US_W            = 32;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timeout_conv_arbiter_if.sv
// Requester and converter bus of the timeout-converter arbiter.
interface timeout_conv_arbiter_if #(
    parameter int NUM_REQ = sensor_pkg::DEF_NUM_REQ
);
    logic [NUM_REQ-1:0]                     req;
    logic [sensor_pkg::MCLKS_W*NUM_REQ-1:0] req_mclks;
    logic [sensor_pkg::PCLKS_W*NUM_REQ-1:0] req_pclks;
    logic [NUM_REQ-1:0]                     ack;
    logic [sensor_pkg::US_W-1:0]            result_us;
    logic                                   result_err;
    logic                                   busy;
    logic                                   conv_start;
    logic [sensor_pkg::MCLKS_W-1:0]         conv_mclks;
    logic [sensor_pkg::PCLKS_W-1:0]         conv_pclks;
    logic                                   conv_done;
    logic [sensor_pkg::US_W-1:0]            conv_us;

    modport slave (
        input  req, req_mclks, req_pclks, conv_done, conv_us,
        output ack, result_us, result_err, busy, conv_start, conv_mclks, conv_pclks
    );

    modport master (
        output req, req_mclks, req_pclks, conv_done, conv_us,
        input  ack, result_us, result_err, busy, conv_start, conv_mclks, conv_pclks
    );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester after last_grant wins.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [IDX_W-1:0]   grant,
    output logic               valid
);

    logic [IDX_W-1:0] cand_s;

    // Walk from farthest to nearest so the nearest requester overwrites last.
    always_comb begin
        grant  = '0;
        valid  = 1'b0;
        cand_s = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand_s]) begin
                grant = cand_s;
                valid = 1'b1;
            end else begin
                grant = grant;
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/timeout_conv_arbiter.sv
// Shares one timeout converter between NUM_REQ requesters with round-robin
// grant, a WAIT watchdog and registered outputs.
module timeout_conv_arbiter
    import sensor_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input logic                   clk,
    input logic                   reset,
    timeout_conv_arbiter_if.slave bus
);

    localparam int IDX_W  = idx_width(NUM_REQ);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [WDOG_W-1:0]  WDOG_MAX = WDOG_W'(WDOG_CYCLES);
    localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

    arb_state_e          state_r, state_nxt_s;
    logic [IDX_W-1:0]    grant_r, grant_nxt_s;
    logic [IDX_W-1:0]    last_grant_r, last_grant_nxt_s;
    logic [WDOG_W-1:0]   wdog_r, wdog_nxt_s;
    logic [NUM_REQ-1:0]  ack_r, ack_nxt_s;
    logic [US_W-1:0]     result_us_r, result_us_nxt_s;
    logic                result_err_r, result_err_nxt_s;
    logic                busy_r;
    logic                conv_start_r;
    logic [MCLKS_W-1:0]  conv_mclks_r, conv_mclks_nxt_s;
    logic [PCLKS_W-1:0]  conv_pclks_r, conv_pclks_nxt_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_valid_s;
    logic [MCLKS_W-1:0]  mclks_arr_s [NUM_REQ];
    logic [PCLKS_W-1:0]  pclks_arr_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign mclks_arr_s[g] = bus.req_mclks[g*MCLKS_W +: MCLKS_W];
        assign pclks_arr_s[g] = bus.req_pclks[g*PCLKS_W +: PCLKS_W];
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req        (bus.req),
        .last_grant (last_grant_r),
        .grant      (pick_idx_s),
        .valid      (pick_valid_s)
    );

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_grant_nxt_s = last_grant_r;
        wdog_nxt_s       = '0;
        ack_nxt_s        = '0;
        result_us_nxt_s  = result_us_r;
        result_err_nxt_s = result_err_r;
        conv_mclks_nxt_s = conv_mclks_r;
        conv_pclks_nxt_s = conv_pclks_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    grant_nxt_s      = pick_idx_s;
                    conv_mclks_nxt_s = mclks_arr_s[pick_idx_s];
                    conv_pclks_nxt_s = pclks_arr_s[pick_idx_s];
                    state_nxt_s      = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                // A real done in the same cycle as expiry still wins.
                if (bus.conv_done) begin
                    result_us_nxt_s  = bus.conv_us;
                    result_err_nxt_s = 1'b0;
                    ack_nxt_s        = ACK_ONE << grant_r;
                    state_nxt_s      = ST_RESPOND;
                end else if (wdog_r == WDOG_MAX) begin
                    result_us_nxt_s  = '0;
                    result_err_nxt_s = 1'b1;
                    ack_nxt_s        = ACK_ONE << grant_r;
                    state_nxt_s      = ST_RESPOND;
                end else begin
                    wdog_nxt_s  = wdog_r + WDOG_W'(1);
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RESPOND: begin
                last_grant_nxt_s = grant_r;
                state_nxt_s      = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; busy/start are derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            last_grant_r <= LAST_IDX;
            wdog_r       <= '0;
            ack_r        <= '0;
            result_us_r  <= '0;
            result_err_r <= 1'b0;
            busy_r       <= 1'b0;
            conv_start_r <= 1'b0;
            conv_mclks_r <= '0;
            conv_pclks_r <= '0;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            wdog_r       <= wdog_nxt_s;
            ack_r        <= ack_nxt_s;
            result_us_r  <= result_us_nxt_s;
            result_err_r <= result_err_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            conv_start_r <= (state_nxt_s == ST_ISSUE);
            conv_mclks_r <= conv_mclks_nxt_s;
            conv_pclks_r <= conv_pclks_nxt_s;
        end
    end

    assign bus.ack        = ack_r;
    assign bus.result_us  = result_us_r;
    assign bus.result_err = result_err_r;
    assign bus.busy       = busy_r;
    assign bus.conv_start = conv_start_r;
    assign bus.conv_mclks = conv_mclks_r;
    assign bus.conv_pclks = conv_pclks_r;

endmodule

// File: tb/tb_timeout_conv_arbiter.sv
// Directed bench for timeout_conv_arbiter with a 4-cycle converter model
// (macro period = (2304*pclks*1687+500)/1000 ns, us = mclks*period/1000).
module tb_timeout_conv_arbiter;

    localparam int NR = 4;
    localparam int WD = 15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    timeout_conv_arbiter_if #(.NUM_REQ(NR)) bus();

    timeout_conv_arbiter #(
        .NUM_REQ     (NR),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Converter model: samples start, pulses done four edges after that.
    logic [4:0]  pipe = '0;
    logic [31:0] conv_res = '0;
    logic        conv_dead = 1'b0;
    logic        spurious = 1'b0;

    function automatic logic [31:0] ref_us(input logic [15:0] m, input logic [7:0] p);
        longint per;
        per = (longint'(p) * 64'd2304 * 64'd1687 + 64'd500) / 64'd1000;
        return 32'((longint'(m) * per) / 64'd1000);
    endfunction

    always @(posedge clk) begin
        pipe <= {pipe[3:0], bus.conv_start};
        if (bus.conv_start) conv_res <= ref_us(bus.conv_mclks, bus.conv_pclks);
    end

    assign bus.conv_done = (pipe[4] & ~conv_dead) | spurious;
    assign bus.conv_us   = conv_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          idx;
        logic [15:0] mclks;
        logic [7:0]  pclks;
        logic [3:0]  exp_ack;
        logic [31:0] exp_us;
    } vec_t;

    vec_t        vecs[5];
    logic [15:0] m_tab[NR];
    logic [7:0]  p_tab[NR];
    int          exp_order[4];

    int          lat, starts;
    logic [3:0]  ack_seen;
    logic [31:0] res;
    logic        err, stable, flag;

    task automatic run_one(input int idx, input logic [15:0] m, input logic [7:0] p);
        @(negedge clk);
        for (int j = 0; j < NR; j++) begin
            bus.req_mclks[j*16 +: 16] = 16'h0b00 + 16'(j);
            bus.req_pclks[j*8 +: 8]   = 8'h50 + 8'(j);
        end
        bus.req_mclks[idx*16 +: 16] = m;
        bus.req_pclks[idx*8 +: 8]   = p;
        bus.req[idx] = 1'b1;
        lat = 0; starts = 0; stable = 1'b1; ack_seen = '0; res = '0; err = 1'b0;
        @(posedge clk); #1;
        for (int n = 1; n <= 40 && ack_seen == 4'd0; n++) begin
            if (bus.conv_start) starts++;
            if (bus.conv_mclks !== m || bus.conv_pclks !== p) stable = 1'b0;
            @(posedge clk); #1;
            if (bus.ack != 4'd0) begin
                lat = n; ack_seen = bus.ack; res = bus.result_us; err = bus.result_err;
            end
        end
        bus.req[idx] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic serve_all(input string tag, input logic [3:0] reqs, input int n);
        int   t;
        logic stab;
        logic [3:0] e;
        t = 0; stab = 1'b1;
        @(negedge clk);
        for (int j = 0; j < NR; j++) begin
            m_tab[j] = 16'(200 + 50 * j);
            p_tab[j] = 8'(8 + 2 * j);
            bus.req_mclks[j*16 +: 16] = m_tab[j];
            bus.req_pclks[j*8 +: 8]   = p_tab[j];
        end
        bus.req = reqs;
        for (int c = 0; c < 300 && t < n; c++) begin
            @(posedge clk); #1;
            if (bus.busy && bus.conv_mclks !== m_tab[exp_order[t]]) stab = 1'b0;
            if (bus.ack != 4'd0) begin
                e = 4'b0001 << exp_order[t];
                chk($sformatf("%s_ack%0d", tag, t), 64'(bus.ack), 64'(e));
                chk($sformatf("%s_us%0d", tag, t), 64'(bus.result_us),
                    64'(ref_us(m_tab[exp_order[t]], p_tab[exp_order[t]])));
                bus.req = bus.req & ~bus.ack;
                t++;
            end
        end
        chk($sformatf("%s_count", tag), 64'(t), 64'(n));
        chk($sformatf("%s_mclks_stable", tag), 64'(stab), 64'd1);
        bus.req = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{0, 16'd100,  8'd14, 4'b0001, 32'd5441};
        vecs[1] = '{1, 16'd200,  8'd10, 4'b0010, 32'd7773};
        vecs[2] = '{2, 16'd50,   8'd18, 4'b0100, 32'd3498};
        vecs[3] = '{3, 16'd1000, 8'd12, 4'b1000, 32'd46642};
        vecs[4] = '{1, 16'd300,  8'd8,  4'b0010, 32'd9328};

        bus.req = '0; bus.req_mclks = '0; bus.req_pclks = '0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 64'(bus.ack), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_start", 64'(bus.conv_start), 64'd0);
        chk("rst_us", 64'(bus.result_us), 64'd0);
        chk("rst_err", 64'(bus.result_err), 64'd0);
        chk("rst_mclks", 64'(bus.conv_mclks), 64'd0);
        chk("rst_pclks", 64'(bus.conv_pclks), 64'd0);
        @(negedge clk) reset = 1'b1;

        for (int v = 0; v < 5; v++) begin
            run_one(vecs[v].idx, vecs[v].mclks, vecs[v].pclks);
            chk($sformatf("v%0d_ack", v), 64'(ack_seen), 64'(vecs[v].exp_ack));
            chk($sformatf("v%0d_us", v), 64'(res), 64'(vecs[v].exp_us));
            chk($sformatf("v%0d_err", v), 64'(err), 64'd0);
            chk($sformatf("v%0d_latency", v), 64'(lat), 64'd6);
            chk($sformatf("v%0d_starts", v), 64'(starts), 64'd1);
            chk($sformatf("v%0d_operands", v), 64'(stable), 64'd1);
        end

        // All four at once after a fresh reset: requester 0 first.
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        exp_order = '{0, 1, 2, 3};
        serve_all("all4", 4'b1111, 4);

        // last_grant = 2, then 1 and 3 together: 3 goes first.
        run_one(2, 16'd77, 8'd9);
        chk("rr_prep_ack", 64'(ack_seen), 64'b0100);
        exp_order = '{3, 1, 0, 0};
        serve_all("rr", 4'b1010, 2);

        // Dead converter: watchdog abort, then a normal transaction.
        conv_dead = 1'b1;
        run_one(0, 16'd100, 8'd14);
        conv_dead = 1'b0;
        chk("wdog_ack", 64'(ack_seen), 64'b0001);
        chk("wdog_latency", 64'(lat), 64'(WD + 2));
        chk("wdog_us", 64'(res), 64'd0);
        chk("wdog_err", 64'(err), 64'd1);
        run_one(3, 16'd300, 8'd8);
        chk("post_wdog_ack", 64'(ack_seen), 64'b1000);
        chk("post_wdog_us", 64'(res), 64'd9328);
        chk("post_wdog_err", 64'(err), 64'd0);
        chk("post_wdog_latency", 64'(lat), 64'd6);

        // Reset during WAIT abandons the transaction.
        @(negedge clk);
        bus.req_mclks[16 +: 16] = 16'd200;
        bus.req_pclks[8 +: 8]   = 8'd10;
        bus.req[1] = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_ack", 64'(bus.ack), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_start", 64'(bus.conv_start), 64'd0);
        chk("midrst_us", 64'(bus.result_us), 64'd0);
        chk("midrst_err", 64'(bus.result_err), 64'd0);
        chk("midrst_mclks", 64'(bus.conv_mclks), 64'd0);
        chk("midrst_pclks", 64'(bus.conv_pclks), 64'd0);
        bus.req[1] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.ack != 4'd0 || bus.busy) flag = 1'b1;
        end
        chk("midrst_no_ack", 64'(flag), 64'd0);
        run_one(1, 16'd200, 8'd10);
        chk("post_rst_ack", 64'(ack_seen), 64'b0010);
        chk("post_rst_us", 64'(res), 64'd7773);
        chk("post_rst_latency", 64'(lat), 64'd6);

        // Spurious done in IDLE, then req[2] dropped during WAIT.
        @(negedge clk) spurious = 1'b1;
        @(negedge clk) spurious = 1'b0;
        flag = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (bus.ack != 4'd0 || bus.busy) flag = 1'b1;
        end
        chk("spur_no_ack", 64'(flag), 64'd0);
        @(negedge clk);
        bus.req_mclks[32 +: 16] = 16'd50;
        bus.req_pclks[16 +: 8]  = 8'd18;
        bus.req[2] = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.req[2] = 1'b0;
        ack_seen = '0; res = '0; err = 1'b1;
        for (int c = 0; c < 40 && ack_seen == 4'd0; c++) begin
            @(posedge clk); #1;
            if (bus.ack != 4'd0) begin
                ack_seen = bus.ack; res = bus.result_us; err = bus.result_err;
            end
        end
        chk("drop_ack", 64'(ack_seen), 64'b0100);
        chk("drop_us", 64'(res), 64'd3498);
        chk("drop_err", 64'(err), 64'd0);
        flag = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.ack != 4'd0) flag = 1'b1;
        end
        chk("drop_no_extra_ack", 64'(flag), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timeout_conv_arbiter.md
TIMEOUT_CONV_ARBITER -- requirements
Module: timeout_conv_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one timeout converter.
REQ-002 Parameter WDOG_CYCLES, default 15, maximum cycles in WAIT before aborting a conversion.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req  in  NUM_REQ  per-requester level request; held until matching ack.
REQ-007 req_mclks  in  16*NUM_REQ  packed timeout operand; slice i belongs to requester i.
REQ-008 req_pclks  in  8*NUM_REQ  packed VCSEL period operand; slice i belongs to requester i.
REQ-009 ack  out  NUM_REQ  one-cycle completion pulse; one-hot.
REQ-010 result_us  out  32  conversion result; valid while ack is high.
REQ-011 result_err  out  1  high with ack when the conversion was aborted by the watchdog.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 conv_start  out  1  start pulse to the converter.
REQ-014 conv_mclks  out  16  converter timeout operand.
REQ-015 conv_pclks  out  8  converter VCSEL operand.
REQ-016 conv_done  in  1  converter one-cycle done pulse.
REQ-017 conv_us  in  32  converter result.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, RESPOND.
REQ-019 In IDLE with any req bit high, the arbiter SHALL grant one requester using round-robin order, searching from (last_grant+1) mod NUM_REQ, then go to ISSUE.
REQ-020 At grant, the granted requester's mclks and pclks slices SHALL be latched into conv_mclks and conv_pclks and held unchanged until the FSM returns to IDLE.
REQ-021 conv_start SHALL be high for exactly the one cycle spent in ISSUE; ISSUE always goes to WAIT.
REQ-022 In WAIT, conv_done high SHALL latch conv_us into result_us, clear result_err, and move to RESPOND.
REQ-023 In WAIT, a watchdog counter SHALL increment every cycle; when it reaches WDOG_CYCLES without conv_done, result_us SHALL be 0, result_err 1, and the FSM SHALL go to RESPOND.
REQ-024 In RESPOND, ack[grant] SHALL be high for one cycle; the FSM then goes to IDLE and last_grant becomes grant.
REQ-025 With the standard 4-cycle converter, ack SHALL go high on the 6th rising edge after the edge that sampled req in IDLE.
REQ-026 Requesters drop req on the edge that samples ack high; the arbiter SHALL NOT compensate for a req held longer, which is treated as a new request.
REQ-027 conv_done seen in IDLE, ISSUE or RESPOND SHALL be ignored.
REQ-028 A req bit that falls before its ack SHALL NOT abort an in-flight conversion; the ack is still issued.
REQ-029 Simultaneous requests SHALL be served one per transaction, with no requester waiting more than NUM_REQ-1 other transactions.
REQ-030 result_us and result_err SHALL hold their value outside RESPOND.

Reset
REQ-031 On reset low: state=IDLE, ack=0, conv_start=0, busy=0, result_us=0, result_err=0, conv_mclks=0, conv_pclks=0, watchdog=0, last_grant=NUM_REQ-1, so requester 0 has first priority.
REQ-032 Reset asserted mid-transaction SHALL abandon the transaction with no ack issued; operation resumes from IDLE after release.

Structure
REQ-033 The shared package sensor_pkg SHALL hold the FSM state encoding, the NUM_REQ and WDOG_CYCLES defaults, and the operand widths 16, 8 and 32.
REQ-034 The round-robin selection SHALL be a combinational sub-module rr_picker (inputs: req, last_grant; output: grant index and valid).

Verification
REQ-035 Single request, real converter: req[0], mclks=100, pclks=14 -> ack[0] six edges later, result_us=5441, result_err=0, conv_start high one cycle.
REQ-036 All four req high simultaneously after reset -> acks in order 0,1,2,3; conv_mclks stable throughout each transaction.
REQ-037 After last_grant=2, req[1] and req[3] both held -> requester 3 served before requester 1.
REQ-038 Stub converter that never pulses done -> ack issued WDOG_CYCLES+2 edges after ISSUE with result_us=0 and result_err=1; the next request completes normally.
REQ-039 Reset pulled low during WAIT -> no ack, all outputs at reset values; a req after release completes with the correct result.
REQ-040 Spurious conv_done injected in IDLE, and req[2] dropped mid-WAIT -> no extra ack from the spurious done; ack[2] still issued.
